// File: rtl/riscv_mem_arb.sv
// Round-robin arbiter that shares one memory port between instruction fetch (IF)
// and execute-stage load/store (EX), with an in-order owner FIFO for response routing.
module riscv_mem_arb #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_rdy,
    output logic              if_req_ack,
    input  logic [AW-1:0]     if_req_addr,
    output logic              if_rsp_rdy,
    input  logic              if_rsp_ack,
    output logic [DW-1:0]     if_rsp_data,

    input  logic              ex_req_rdy,
    output logic              ex_req_ack,
    input  logic [AW-1:0]     ex_req_addr,
    input  logic              ex_req_we,
    input  logic [DW/8-1:0]   ex_req_be,
    input  logic [DW-1:0]     ex_req_wdata,
    output logic              ex_rsp_rdy,
    input  logic              ex_rsp_ack,
    output logic [DW-1:0]     ex_rsp_data,

    output logic              mem_req_rdy,
    input  logic              mem_req_ack,
    output logic [AW-1:0]     mem_req_addr,
    output logic              mem_req_we,
    output logic [DW/8-1:0]   mem_req_be,
    output logic [DW-1:0]     mem_req_wdata,
    input  logic              mem_rsp_rdy,
    output logic              mem_rsp_ack,
    input  logic [DW-1:0]     mem_rsp_data,

    output logic              err
);
    localparam int   PW     = $clog2(DEPTH);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_EX = 1'b1;

    logic             last_grant_q, last_grant_d;
    logic             lock_q, lock_d;
    logic             lock_owner_q, lock_owner_d;
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] owner_q, owner_d;
    logic             err_q, err_d;

    logic grant;
    logic granted_rdy;
    logic full;
    logic empty;
    logic head;
    logic push;
    logic pop;
    logic req_ack;
    logic rsp_live;

    // Request side: grant selection and muxing are purely combinational.
    always_comb begin
        full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);

        if (lock_q) begin
            grant = lock_owner_q;
        end else if (if_req_rdy && ex_req_rdy) begin
            grant = (last_grant_q == OWN_IF) ? OWN_EX : OWN_IF;
        end else if (ex_req_rdy) begin
            grant = OWN_EX;
        end else begin
            grant = OWN_IF;
        end

        granted_rdy = (grant == OWN_EX) ? ex_req_rdy : if_req_rdy;
        mem_req_rdy = !rst && granted_rdy && !full;
        req_ack     = !rst && mem_req_ack && !full;
        if_req_ack  = req_ack && (grant == OWN_IF);
        ex_req_ack  = req_ack && (grant == OWN_EX);
        push        = mem_req_rdy && mem_req_ack;

        if (grant == OWN_EX) begin
            mem_req_addr  = ex_req_addr;
            mem_req_we    = ex_req_we;
            mem_req_be    = ex_req_be;
            mem_req_wdata = ex_req_wdata;
        end else begin
            mem_req_addr  = if_req_addr;
            mem_req_we    = 1'b0;
            mem_req_be    = '1;
            mem_req_wdata = '0;
        end
    end

    // Response side: the oldest outstanding tag decides who sees the response.
    always_comb begin
        head        = owner_q[rd_ptr_q[PW-1:0]];
        rsp_live    = !rst && !empty && mem_rsp_rdy;
        if_rsp_rdy  = rsp_live && (head == OWN_IF);
        ex_rsp_rdy  = rsp_live && (head == OWN_EX);
        mem_rsp_ack = !rst && !empty && ((head == OWN_EX) ? ex_rsp_ack : if_rsp_ack);
        pop         = rsp_live && mem_rsp_ack;
        if_rsp_data = mem_rsp_data;
        ex_rsp_data = mem_rsp_data;
        err         = err_q;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d     = rd_ptr_q + (PW+1)'(pop);
        last_grant_d = push ? grant : last_grant_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        owner_d      = owner_q;
        err_d        = err_q || (mem_rsp_rdy && empty);

        // A presented but unaccepted request pins the grant until memory takes it.
        if (push) begin
            lock_d = 1'b0;
        end else if (mem_req_rdy) begin
            lock_d       = 1'b1;
            lock_owner_d = grant;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr_q[PW-1:0] == PW'(i))) begin
                owner_d[i] = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_IF;
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_IF;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            owner_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Self-checking bench for riscv_mem_arb: directed scenarios plus a randomized run
// checked against a transaction-level scoreboard of owners and response data.
`timescale 1ns/1ps
module tb_riscv_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW/8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_rdy, if_req_ack, if_rsp_rdy, if_rsp_ack;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_rsp_data;
    logic          ex_req_rdy, ex_req_ack, ex_req_we, ex_rsp_rdy, ex_rsp_ack;
    logic [AW-1:0] ex_req_addr;
    logic [BW-1:0] ex_req_be;
    logic [DW-1:0] ex_req_wdata, ex_rsp_data;
    logic          mem_req_rdy, mem_req_ack, mem_req_we, mem_rsp_rdy, mem_rsp_ack;
    logic [AW-1:0] mem_req_addr;
    logic [BW-1:0] mem_req_be;
    logic [DW-1:0] mem_req_wdata, mem_rsp_data;
    logic          err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_mem_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_req_rdy(if_req_rdy), .if_req_ack(if_req_ack), .if_req_addr(if_req_addr),
        .if_rsp_rdy(if_rsp_rdy), .if_rsp_ack(if_rsp_ack), .if_rsp_data(if_rsp_data),
        .ex_req_rdy(ex_req_rdy), .ex_req_ack(ex_req_ack), .ex_req_addr(ex_req_addr),
        .ex_req_we(ex_req_we), .ex_req_be(ex_req_be), .ex_req_wdata(ex_req_wdata),
        .ex_rsp_rdy(ex_rsp_rdy), .ex_rsp_ack(ex_rsp_ack), .ex_rsp_data(ex_rsp_data),
        .mem_req_rdy(mem_req_rdy), .mem_req_ack(mem_req_ack), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_ack(mem_rsp_ack), .mem_rsp_data(mem_rsp_data),
        .err(err)
    );

    task automatic clear_inputs();
        if_req_rdy = 0; if_req_addr = '0; if_rsp_ack = 0;
        ex_req_rdy = 0; ex_req_addr = '0; ex_req_we = 0; ex_req_be = '0; ex_req_wdata = '0;
        ex_rsp_ack = 0; mem_req_ack = 0; mem_rsp_rdy = 0; mem_rsp_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        if_req_rdy = 1; ex_req_rdy = 1; mem_req_ack = 1; mem_rsp_rdy = 1;
        if_rsp_ack = 1; ex_rsp_ack = 1;
        @(negedge clk);
        checks++;
        if ({if_req_ack, ex_req_ack, mem_req_rdy, if_rsp_rdy, ex_rsp_rdy, mem_rsp_ack} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {if_req_ack, ex_req_ack, mem_req_rdy, if_rsp_rdy, ex_rsp_rdy, mem_rsp_ack});
        end
        tick();
        rst = 0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || mem_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got err=%b mem_req_rdy=%b want 0 0", err, mem_req_rdy);
        end
        tick();
    endtask

    task automatic test_single_if();
        do_reset();
        if_req_rdy = 1; if_req_addr = 32'h0000_0100; mem_req_ack = 1;
        @(negedge clk);
        checks++;
        if (if_req_ack !== 1'b1 || ex_req_ack !== 1'b0 || mem_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL single_if_ack: got if_ack=%b ex_ack=%b mem_rdy=%b want 1 0 1",
                     if_req_ack, ex_req_ack, mem_req_rdy);
        end
        checks++;
        if (mem_req_addr !== 32'h100 || mem_req_we !== 1'b0 || mem_req_be !== 4'hF || mem_req_wdata !== '0) begin
            failures++;
            $display("FAIL single_if_fields: got addr=%h we=%b be=%h wdata=%h want 100 0 f 0",
                     mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata);
        end
        tick();
        if_req_rdy = 0; mem_req_ack = 0;
        mem_rsp_rdy = 1; mem_rsp_data = 32'hDEAD_BEEF; if_rsp_ack = 1;
        @(negedge clk);
        checks++;
        if (if_rsp_rdy !== 1'b1 || if_rsp_data !== 32'hDEAD_BEEF || ex_rsp_rdy !== 1'b0
            || mem_rsp_ack !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_if_rsp: got rdy=%b data=%h ex_rdy=%b ack=%b err=%b want 1 deadbeef 0 1 0",
                     if_rsp_rdy, if_rsp_data, ex_rsp_rdy, mem_rsp_ack, err);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_alternate();
        logic exp_ex;
        do_reset();
        if_req_rdy = 1; ex_req_rdy = 1; mem_req_ack = 1;
        exp_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_req_addr = 32'h1000 + i; ex_req_addr = 32'h2000 + i;
            @(negedge clk);
            checks++;
            if (ex_req_ack !== exp_ex || if_req_ack !== !exp_ex) begin
                failures++;
                $display("FAIL alternate_grant%0d: got ex_ack=%b if_ack=%b want ex_ack=%b", i, ex_req_ack, if_req_ack, exp_ex);
            end
            exp_ex = !exp_ex;
            tick();
        end
        if_req_rdy = 0; ex_req_rdy = 0; mem_req_ack = 0;
        if_rsp_ack = 1; ex_rsp_ack = 1; mem_rsp_rdy = 1;
        exp_ex = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            mem_rsp_data = DW'(i);
            @(negedge clk);
            checks++;
            if (ex_rsp_rdy !== exp_ex || if_rsp_rdy !== !exp_ex
                || (exp_ex ? ex_rsp_data : if_rsp_data) !== DW'(i)) begin
                failures++;
                $display("FAIL alternate_rsp%0d: got ex_rdy=%b if_rdy=%b want ex_rdy=%b data %0h", i,
                         ex_rsp_rdy, if_rsp_rdy, exp_ex, i);
            end
            exp_ex = !exp_ex;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        ex_req_rdy = 1; ex_req_addr = 32'hA0; mem_req_ack = 1;
        @(negedge clk);
        checks++;
        if (ex_req_ack !== 1'b1) begin
            failures++;
            $display("FAIL lock_first_ex: got ex_ack=%b want 1", ex_req_ack);
        end
        tick();
        // EX presented and refused; IF then joins while the tie would otherwise go to IF
        ex_req_addr = 32'hB0; ex_req_we = 1; ex_req_be = 4'h3; ex_req_wdata = 32'h1234_5678;
        mem_req_ack = 0;
        tick();
        if_req_rdy = 1; if_req_addr = 32'hC0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_addr !== 32'hB0 || mem_req_we !== 1'b1 || mem_req_wdata !== 32'h1234_5678
                || if_req_ack !== 1'b0 || mem_req_rdy !== 1'b1) begin
                failures++;
                $display("FAIL lock_hold%0d: got addr=%h we=%b if_ack=%b rdy=%b want b0 1 0 1",
                         i, mem_req_addr, mem_req_we, if_req_ack, mem_req_rdy);
            end
            tick();
        end
        mem_req_ack = 1;
        @(negedge clk);
        checks++;
        if (ex_req_ack !== 1'b1 || if_req_ack !== 1'b0) begin
            failures++;
            $display("FAIL lock_release: got ex_ack=%b if_ack=%b want 1 0", ex_req_ack, if_req_ack);
        end
        tick();
        ex_req_rdy = 1; ex_req_addr = 32'hD0;
        @(negedge clk);
        checks++;
        if (if_req_ack !== 1'b1 || mem_req_addr !== 32'hC0) begin
            failures++;
            $display("FAIL lock_next_if: got if_ack=%b addr=%h want 1 c0", if_req_ack, mem_req_addr);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        if_req_rdy = 1; mem_req_ack = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if_req_addr = 32'h300 + 4*i;
            @(negedge clk);
            checks++;
            if (if_req_ack !== 1'b1) begin
                failures++;
                $display("FAIL full_fill%0d: got if_ack=%b want 1", i, if_req_ack);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (mem_req_rdy !== 1'b0 || if_req_ack !== 1'b0) begin
            failures++;
            $display("FAIL full_block: got rdy=%b if_ack=%b want 0 0", mem_req_rdy, if_req_ack);
        end
        tick();
        mem_rsp_rdy = 1; mem_rsp_data = 32'h55; if_rsp_ack = 1;
        @(negedge clk);
        checks++;
        if (mem_rsp_ack !== 1'b1 || mem_req_rdy !== 1'b0 || if_req_ack !== 1'b0) begin
            failures++;
            $display("FAIL full_same_cycle: got rsp_ack=%b req_rdy=%b if_ack=%b want 1 0 0",
                     mem_rsp_ack, mem_req_rdy, if_req_ack);
        end
        tick();
        mem_rsp_rdy = 0; if_rsp_ack = 0;
        @(negedge clk);
        checks++;
        if (if_req_ack !== 1'b1 || mem_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL full_after_pop: got if_ack=%b rdy=%b want 1 1", if_req_ack, mem_req_rdy);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_empty_err();
        do_reset();
        mem_rsp_rdy = 1; if_rsp_ack = 1; ex_rsp_ack = 1;
        @(negedge clk);
        checks++;
        if (mem_rsp_ack !== 1'b0 || if_rsp_rdy !== 1'b0 || ex_rsp_rdy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL empty_rsp: got ack=%b if=%b ex=%b err=%b want 0 0 0 0",
                     mem_rsp_ack, if_rsp_rdy, ex_rsp_rdy, err);
        end
        tick();
        clear_inputs();
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL empty_err_sticky: got err=%b want 1", err);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL empty_err_clear: got err=%b want 0", err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req_rdy = 1; mem_req_ack = 1;
        repeat (2) tick();
        rst = 1; ex_req_rdy = 1; mem_rsp_rdy = 1; if_rsp_ack = 1; ex_rsp_ack = 1;
        @(negedge clk);
        checks++;
        if ({if_req_ack, ex_req_ack, mem_req_rdy, if_rsp_rdy, ex_rsp_rdy, mem_rsp_ack} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got %b want 000000",
                     {if_req_ack, ex_req_ack, mem_req_rdy, if_rsp_rdy, ex_rsp_rdy, mem_rsp_ack});
        end
        tick();
        rst = 0; mem_rsp_rdy = 0; if_rsp_ack = 0; ex_rsp_ack = 0;
        @(negedge clk);
        checks++;
        if (ex_req_ack !== 1'b1 || if_req_ack !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_tie: got ex_ack=%b if_ack=%b err=%b want 1 0 0", ex_req_ack, if_req_ack, err);
        end
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_rdy !== (i < DEPTH)) begin
                failures++;
                $display("FAIL midreset_capacity%0d: got rdy=%b want %b", i, mem_req_rdy, i < DEPTH);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic          exp_owner[$];
        logic [DW-1:0] exp_data[$];
        logic [DW-1:0] mem_q[$];
        logic          if_pend = 0, ex_pend = 0, rsp_pend = 0;
        logic          prev_stall = 0;
        logic [AW-1:0] prev_addr = '0;
        int            last_acc = -1;
        logic          other_was_rdy = 0;
        logic          it, et, mt, ir, er, rt;
        logic [DW-1:0] seq = 32'hA000_0000;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!if_pend && $urandom_range(2) == 0) begin
                if_pend = 1; if_req_addr = $urandom & ~32'h3;
            end
            if (!ex_pend && $urandom_range(2) == 0) begin
                ex_pend = 1; ex_req_addr = $urandom; ex_req_we = 1'($urandom);
                ex_req_be = 4'($urandom); ex_req_wdata = $urandom;
            end
            if_req_rdy = if_pend; ex_req_rdy = ex_pend;
            mem_req_ack = 1'($urandom);
            if (!rsp_pend && mem_q.size() > 0 && $urandom_range(1) == 1) rsp_pend = 1;
            mem_rsp_rdy = rsp_pend;
            mem_rsp_data = rsp_pend ? mem_q[0] : $urandom;
            if_rsp_ack = 1'($urandom); ex_rsp_ack = 1'($urandom);
            @(negedge clk);

            if (prev_stall) begin
                checks++;
                if (mem_req_rdy !== 1'b1 || mem_req_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL rand_hold c%0d: got rdy=%b addr=%h want 1 %h", cyc, mem_req_rdy, mem_req_addr, prev_addr);
                end
            end
            prev_stall = mem_req_rdy && !mem_req_ack;
            prev_addr = mem_req_addr;

            mt = mem_req_rdy && mem_req_ack;
            it = if_req_rdy && if_req_ack;
            et = ex_req_rdy && ex_req_ack;
            checks++;
            if (mt !== (it || et) || (it && et)) begin
                failures++;
                $display("FAIL rand_req_xfer c%0d: got mem=%b if=%b ex=%b want one matching", cyc, mt, it, et);
            end
            if (it || et) begin
                checks++;
                if (it ? (mem_req_addr !== if_req_addr || mem_req_we !== 1'b0 || mem_req_be !== 4'hF || mem_req_wdata !== '0)
                       : (mem_req_addr !== ex_req_addr || mem_req_we !== ex_req_we || mem_req_be !== ex_req_be
                          || mem_req_wdata !== ex_req_wdata)) begin
                    failures++;
                    $display("FAIL rand_fields c%0d: got addr=%h we=%b be=%h wd=%h for owner %s",
                             cyc, mem_req_addr, mem_req_we, mem_req_be, mem_req_wdata, it ? "IF" : "EX");
                end
                checks++;
                if (last_acc == int'(et) && other_was_rdy) begin
                    failures++;
                    $display("FAIL rand_fairness c%0d: got %s twice while other waited, want alternate", cyc, et ? "EX" : "IF");
                end
                checks++;
                if (exp_owner.size() >= DEPTH) begin
                    failures++;
                    $display("FAIL rand_depth c%0d: got %0d outstanding before accept, want <%0d", cyc, exp_owner.size(), DEPTH);
                end
                last_acc = int'(et);
                other_was_rdy = et ? if_req_rdy : ex_req_rdy;
                seq++;
                exp_owner.push_back(et);
                exp_data.push_back(seq);
                mem_q.push_back(seq);
                $display("REQ c%0d owner=%s addr=%h tag=%h", cyc, et ? "EX" : "IF", mem_req_addr, seq);
                if (it) if_pend = 0; else ex_pend = 0;
            end

            rt = mem_rsp_rdy && mem_rsp_ack;
            ir = if_rsp_rdy && if_rsp_ack;
            er = ex_rsp_rdy && ex_rsp_ack;
            checks++;
            if (rt !== (ir || er) || (if_rsp_rdy && ex_rsp_rdy) || err !== 1'b0) begin
                failures++;
                $display("FAIL rand_rsp_xfer c%0d: got mem=%b if=%b ex=%b err=%b", cyc, rt, ir, er, err);
            end
            if (rt && exp_owner.size() > 0) begin
                checks++;
                if (exp_owner[0] !== er || (er ? ex_rsp_data : if_rsp_data) !== exp_data[0]) begin
                    failures++;
                    $display("FAIL rand_route c%0d: got %s data=%h want %s data=%h", cyc, er ? "EX" : "IF",
                             er ? ex_rsp_data : if_rsp_data, exp_owner[0] ? "EX" : "IF", exp_data[0]);
                end
                $display("RSP c%0d owner=%s data=%h", cyc, er ? "EX" : "IF", mem_rsp_data);
                void'(exp_owner.pop_front());
                void'(exp_data.pop_front());
                void'(mem_q.pop_front());
                rsp_pend = 0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        tick();
        test_reset();
        test_single_if();
        test_alternate();
        test_lock();
        test_full();
        test_empty_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
